// File: rtl/conv3x3_window_mac_pkg.sv
// conv3x3_window_mac_pkg: shared fixed-point format, state encoding and saturation limits for the conv blocks
package conv3x3_window_mac_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS = 16;
  localparam int TAPS = 9;
  localparam int PSUMS = 5;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W = 2 * DATA_WIDTH + 4;
  typedef enum logic {LOAD, RUN} state_e;
  typedef logic signed [DATA_WIDTH-1:0] word_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0] sum_t;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [31:0] row;
    logic [31:0] col;
  } tag_t;
  function automatic logic signed [63:0] sat_hi(int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_lo(int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/conv3x3_window_mac_if.sv
// conv3x3_window_mac_if: weight port, window taps in and tagged pixel stream out
interface conv3x3_window_mac_if;
  import conv3x3_window_mac_pkg::*;
  logic [DATA_WIDTH-1:0] Weight_In;
  logic                  Weight_Valid;
  logic                  Weight_Reload;
  logic [DATA_WIDTH-1:0] Win_In1, Win_In2, Win_In3, Win_In4, Win_In5, Win_In6, Win_In7, Win_In8, Win_In9;
  logic                  Win_Valid;
  logic                  Weights_Loaded;
  logic [DATA_WIDTH-1:0] Data_Out;
  logic                  Valid_Out;
  logic [31:0]           Row_Out;
  logic [31:0]           Col_Out;
  logic                  Frame_Done;
  modport master (
    output Weight_In, Weight_Valid, Weight_Reload, Win_Valid,
    output Win_In1, Win_In2, Win_In3, Win_In4, Win_In5, Win_In6, Win_In7, Win_In8, Win_In9,
    input  Weights_Loaded, Data_Out, Valid_Out, Row_Out, Col_Out, Frame_Done
  );
  modport slave (
    input  Weight_In, Weight_Valid, Weight_Reload, Win_Valid,
    input  Win_In1, Win_In2, Win_In3, Win_In4, Win_In5, Win_In6, Win_In7, Win_In8, Win_In9,
    output Weights_Loaded, Data_Out, Valid_Out, Row_Out, Col_Out, Frame_Done
  );
endinterface

// File: rtl/conv_sat_shift.sv
// conv_sat_shift: arithmetic right shift of a wide sum, saturated to OUT_W signed bits
module conv_sat_shift
  import conv3x3_window_mac_pkg::*;
#(
  parameter int IN_W  = SUM_W,
  parameter int OUT_W = DATA_WIDTH,
  parameter int SHIFT = FRAC_BITS
) (
  input  logic signed [IN_W-1:0]  sum_i,
  output logic signed [OUT_W-1:0] sat_o
);
  localparam logic signed [IN_W-1:0] HI = IN_W'(sat_hi(OUT_W));
  localparam logic signed [IN_W-1:0] LO = IN_W'(sat_lo(OUT_W));
  logic signed [IN_W-1:0] r;
  always_comb begin
    r = sum_i >>> SHIFT;
    sat_o = r > HI ? OUT_W'(HI) : r < LO ? OUT_W'(LO) : OUT_W'(r);
  end
endmodule

// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: 4-stage pipelined 3x3 window multiply-accumulate with serial weight load and raster tagging
module conv3x3_window_mac
  import conv3x3_window_mac_pkg::*;
#(
  parameter int IMG_WIDTH  = 299,
  parameter int IMG_HEIGHT = 299
) (
  input logic clk,
  input logic rst,
  conv3x3_window_mac_if.slave bus
);
  state_e      state_q, state_d;
  logic [3:0]  widx_q, widx_d;
  word_t       w_q [TAPS];
  word_t       w_d [TAPS];
  word_t       bias_q, bias_d;
  logic [31:0] row_q, row_d, col_q, col_d;
  prod_t       prod_q [TAPS];
  prod_t       prod_d [TAPS];
  sum_t        bias_sh_q, bias_sh_d;
  sum_t        psum_q [PSUMS];
  sum_t        psum_d [PSUMS];
  sum_t        sum_q, sum_d;
  tag_t        t1_q, t1_d, t2_q, t2_d, t3_q, t3_d, out_q, out_d;
  word_t       data_q, data_d;
  word_t       win [TAPS];
  word_t       sat;
  logic        flush, load_en, accept, last;
  assign win = '{bus.Win_In1, bus.Win_In2, bus.Win_In3, bus.Win_In4, bus.Win_In5,
                 bus.Win_In6, bus.Win_In7, bus.Win_In8, bus.Win_In9};
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= LOAD;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (flush) state_d = LOAD;
    else if (load_en && widx_q == 4'(TAPS)) state_d = RUN;
  end
  // Reload wins over any weight word or window offered in the same cycle
  always_comb begin
    flush = bus.Weight_Reload;
    load_en = state_q == LOAD && bus.Weight_Valid && !flush;
    accept = state_q == RUN && bus.Win_Valid && !flush;
    bus.Weights_Loaded = state_q == RUN;
  end
  always_comb begin
    w_d = w_q;
    bias_d = bias_q;
    widx_d = widx_q;
    row_d = row_q;
    col_d = col_q;
    last = row_q == 32'(IMG_HEIGHT - 1) && col_q == 32'(IMG_WIDTH - 1);
    if (flush) begin
      widx_d = '0;
      row_d = '0;
      col_d = '0;
    end else begin
      if (load_en) begin
        if (widx_q == 4'(TAPS)) bias_d = bus.Weight_In;
        else w_d[widx_q] = bus.Weight_In;
        widx_d = widx_q == 4'(TAPS) ? '0 : widx_q + 4'd1;
      end
      if (accept) begin
        col_d = col_q == 32'(IMG_WIDTH - 1) ? '0 : col_q + 32'd1;
        row_d = col_q != 32'(IMG_WIDTH - 1) ? row_q : last ? '0 : row_q + 32'd1;
      end
    end
    for (int k = 0; k < TAPS; k++) prod_d[k] = PROD_W'(win[k]) * PROD_W'(w_q[k]);
    bias_sh_d = SUM_W'(bias_q) <<< FRAC_BITS;
    for (int k = 0; k < PSUMS - 1; k++) psum_d[k] = SUM_W'(prod_q[2*k]) + SUM_W'(prod_q[2*k+1]);
    psum_d[PSUMS-1] = SUM_W'(prod_q[TAPS-1]) + bias_sh_q;
    sum_d = '0;
    for (int k = 0; k < PSUMS; k++) sum_d = sum_d + psum_q[k];
    t1_d = '{valid: accept, last: last, row: row_q, col: col_q};
    t2_d = t1_q;
    t2_d.valid = t1_q.valid && !flush;
    t3_d = t2_q;
    t3_d.valid = t2_q.valid && !flush;
    out_d = t3_q;
    out_d.valid = t3_q.valid && !flush;
    out_d.last = t3_q.last && out_d.valid;
    data_d = out_d.valid ? sat : '0;
  end
  conv_sat_shift #(.IN_W(SUM_W), .OUT_W(DATA_WIDTH), .SHIFT(FRAC_BITS)) u_sat (
    .sum_i(sum_q),
    .sat_o(sat)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      widx_q <= '0;
      w_q <= '{default: '0};
      bias_q <= '0;
      row_q <= '0;
      col_q <= '0;
      prod_q <= '{default: '0};
      bias_sh_q <= '0;
      psum_q <= '{default: '0};
      sum_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      t3_q <= '0;
      out_q <= '0;
      data_q <= '0;
    end else begin
      widx_q <= widx_d;
      w_q <= w_d;
      bias_q <= bias_d;
      row_q <= row_d;
      col_q <= col_d;
      prod_q <= prod_d;
      bias_sh_q <= bias_sh_d;
      psum_q <= psum_d;
      sum_q <= sum_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
      t3_q <= t3_d;
      out_q <= out_d;
      data_q <= data_d;
    end
  assign bus.Data_Out = data_q;
  assign bus.Valid_Out = out_q.valid;
  assign bus.Row_Out = out_q.row;
  assign bus.Col_Out = out_q.col;
  assign bus.Frame_Done = out_q.last;
endmodule

// File: tb/tb_conv3x3_window_mac.sv
// tb_conv3x3_window_mac: directed and random windows checked against an arithmetic reference with a timestamped queue
module tb_conv3x3_window_mac;
  localparam int IW = 4;
  localparam int IH = 3;
  logic clk = 0;
  logic rst = 0;
  conv3x3_window_mac_if bus();
  conv3x3_window_mac #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    int          due;
    logic [31:0] data;
    int          row;
    int          col;
    logic        done;
  } exp_t;
  exp_t q[$];
  logic [31:0] wt [9];
  logic [31:0] bias;
  logic [31:0] tp [9];
  logic [31:0] wv [9];
  logic [31:0] zero9 [9];
  bit run = 0;
  int widx = 0, row_m = 0, col_m = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Real-valued sum scaled by 2^-16, floored, then clamped to the signed 32-bit range
  function automatic logic [31:0] ref_pix(input logic [31:0] t [9]);
    logic signed [127:0] s, r;
    s = 128'($signed(bias)) * 128'sd65536;
    for (int k = 0; k < 9; k++) s = s + 128'($signed(t[k])) * 128'($signed(wt[k]));
    r = s / 128'sd65536;
    if (s < 0 && s % 128'sd65536 != 0) r = r - 1;
    if (r > 128'sd2147483647) return 32'h7fffffff;
    if (r < -128'sd2147483648) return 32'h80000000;
    return r[31:0];
  endfunction

  function automatic logic [31:0] rnd();
    logic [31:0] r = $urandom;
    return ($urandom_range(0, 3) == 0) ? r : {{12{r[19]}}, r[19:0]};
  endfunction

  task automatic drive(input bit wvld, input logic [31:0] wd, input bit winv, input logic [31:0] t [9], input bit rl);
    @(posedge clk);
    #1;
    chk("weights_loaded", 64'(bus.Weights_Loaded), 64'(run));
    bus.Weight_Valid = wvld;
    bus.Weight_In = wd;
    bus.Weight_Reload = rl;
    bus.Win_Valid = winv;
    {bus.Win_In1, bus.Win_In2, bus.Win_In3, bus.Win_In4, bus.Win_In5,
     bus.Win_In6, bus.Win_In7, bus.Win_In8, bus.Win_In9} = {t[0], t[1], t[2], t[3], t[4], t[5], t[6], t[7], t[8]};
    if (rl) begin
      while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
      run = 0;
      widx = 0;
      row_m = 0;
      col_m = 0;
    end else begin
      if (winv && run) begin
        q.push_back('{cyc + 4, ref_pix(t), row_m, col_m, row_m == IH - 1 && col_m == IW - 1});
        if (col_m == IW - 1) begin
          col_m = 0;
          row_m = (row_m == IH - 1) ? 0 : row_m + 1;
        end else col_m++;
      end
      if (wvld && !run) begin
        if (widx < 9) wt[widx] = wd;
        else bias = wd;
        if (widx == 9) begin
          run = 1;
          widx = 0;
        end else widx++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, zero9, 0);
  endtask

  task automatic window(input logic [31:0] t [9]);
    drive(0, 0, 1, t, 0);
  endtask

  task automatic reload();
    drive(1, 32'h1234_5678, 1, zero9, 1);
  endtask

  task automatic load(input logic [31:0] w [9], input logic [31:0] b);
    for (int k = 0; k < 9; k++) drive(1, w[k], 0, zero9, 0);
    drive(1, b, 0, zero9, 0);
  endtask

  task automatic rand_windows(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      for (int k = 0; k < 9; k++) tp[k] = rnd();
      window(tp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_loaded", 64'(bus.Weights_Loaded), 64'd0);
    chk("rst_valid", 64'(bus.Valid_Out), 64'd0);
    chk("rst_data", 64'(bus.Data_Out), 64'd0);
    chk("rst_row", 64'(bus.Row_Out), 64'd0);
    chk("rst_col", 64'(bus.Col_Out), 64'd0);
    chk("rst_done", 64'(bus.Frame_Done), 64'd0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("out_valid", 64'(bus.Valid_Out), 64'd1);
      chk("out_data", 64'(bus.Data_Out), 64'(q[0].data));
      chk("out_row", 64'(bus.Row_Out), 64'(q[0].row));
      chk("out_col", 64'(bus.Col_Out), 64'(q[0].col));
      chk("out_done", 64'(bus.Frame_Done), 64'(q[0].done));
      void'(q.pop_front());
    end else begin
      chk("idle_valid", 64'(bus.Valid_Out), 64'd0);
      chk("idle_data", 64'(bus.Data_Out), 64'd0);
      chk("idle_done", 64'(bus.Frame_Done), 64'd0);
    end
  end

  initial begin
    zero9 = '{default: 32'h0};
    wt = '{default: 32'h0};
    bias = 0;
    bus.Weight_Valid = 0;
    bus.Weight_In = 0;
    bus.Weight_Reload = 0;
    bus.Win_Valid = 0;
    {bus.Win_In1, bus.Win_In2, bus.Win_In3, bus.Win_In4, bus.Win_In5,
     bus.Win_In6, bus.Win_In7, bus.Win_In8, bus.Win_In9} = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1;
    // windows offered before any weights are loaded
    rand_windows(3, 0);
    // identity kernel
    wv = '{default: 32'h0};
    wv[4] = 32'h0001_0000;
    load(wv, 32'h0);
    tp = '{default: 32'h0};
    tp[4] = 32'h0005_0000;
    window(tp);
    idle(6);
    // full sum with bias; reload also carries a stray weight word and window
    reload();
    wv = '{default: 32'h0001_0000};
    load(wv, 32'h0001_0000);
    tp = '{default: 32'h0002_0000};
    window(tp);
    idle(6);
    // saturation in both directions, back to back
    reload();
    wv = '{default: 32'h7fff_0000};
    load(wv, 32'h0);
    tp = '{default: 32'h7fff_0000};
    window(tp);
    tp = '{default: 32'h8001_0000};
    window(tp);
    idle(6);
    // frame tagging with gapped input, wrapping into the next frame
    reload();
    for (int k = 0; k < 9; k++) wv[k] = rnd();
    load(wv, rnd());
    rand_windows(13, 1);
    idle(6);
    // reload with results in flight
    rand_windows(5, 0);
    reload();
    idle(6);
    for (int k = 0; k < 9; k++) wv[k] = rnd();
    load(wv, rnd());
    rand_windows(2, 0);
    idle(6);
    rand_windows(30, 1);
    idle(2);
    // asynchronous reset with results in flight
    rand_windows(4, 0);
    @(posedge clk);
    #1;
    rst = 0;
    run = 0;
    widx = 0;
    row_m = 0;
    col_m = 0;
    while (q.size() > 0 && q[q.size()-1].due >= cyc) void'(q.pop_back());
    bus.Win_Valid = 0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1;
    rand_windows(3, 0);
    for (int k = 0; k < 9; k++) wv[k] = rnd();
    load(wv, rnd());
    rand_windows(6, 1);
    idle(8);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
